// File: rtl/reg_file_param.sv
// Parametrised register file: one synchronous write port, two combinational read ports,
// and a sequential clear sweep with BUSY stall and WRITE_DROP reporting. Define REG_FILE_FWD_EN for write-to-read forwarding.
module reg_file_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int RD_DLY = 2,
    parameter int WR_DLY = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    input  logic              CLEAR,
    output logic              BUSY,
    output logic              WRITE_DROP
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH-1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    // RD_DLY/WR_DLY describe event-driven timing only; this implementation is zero-delay.
    if (RD_DLY < 0 || WR_DLY < 0) begin : g_neg_dly_unsupported
    end

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              drop_q, drop_d;
    logic              wr_en_s;
    logic              clr_en_s;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Next-state logic for the sweep FSM, counter and write-drop flag.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        drop_d   = 1'b0;
        wr_en_s  = 1'b0;
        clr_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (CLEAR) begin
                    state_d = SWEEP;
                    cnt_d   = {(ADDR_W+1){1'b0}};
                    drop_d  = WRITE;
                end else begin
                    wr_en_s = WRITE;
                end
            end
            SWEEP: begin
                clr_en_s = 1'b1;
                cnt_d    = cnt_q + {{ADDR_W{1'b0}}, 1'b1};
                drop_d   = WRITE;
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                end else begin
                    state_d = SWEEP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, sweep counter and write-drop flag registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= {(ADDR_W+1){1'b0}};
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Register array: accepted writes in IDLE, one ascending clear per cycle in SWEEP.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_q[INADDRESS] <= IN;
        end else if (clr_en_s) begin
            mem_q[cnt_q[ADDR_W-1:0]] <= {DATA_W{1'b0}};
        end else begin
            mem_q[0] <= mem_q[0];
        end
    end

    // Asynchronous read ports; forwarding only ever shows a write that will be accepted.
    always_comb begin
        OUT1 = mem_q[OUT1ADDRESS];
        OUT2 = mem_q[OUT2ADDRESS];
`ifdef REG_FILE_FWD_EN
        if (wr_en_s && (OUT1ADDRESS == INADDRESS)) begin
            OUT1 = IN;
        end else begin
            OUT1 = mem_q[OUT1ADDRESS];
        end
        if (wr_en_s && (OUT2ADDRESS == INADDRESS)) begin
            OUT2 = IN;
        end else begin
            OUT2 = mem_q[OUT2ADDRESS];
        end
`endif
    end

    assign BUSY       = (state_q == SWEEP);
    assign WRITE_DROP = drop_q;

endmodule
